// File: rtl/argmax_if.sv
// argmax_if: logit stream and result bundle for argmax_unit.
//   start          frame start / restart request
//   in_valid       in_data carries a logit this cycle
//   in_data        signed logit; beat k of a frame is class k
//   in_ready       unit accepts a beat this cycle
//   busy           unit is collecting a frame
//   done           one-cycle pulse when a new result is committed
//   argmax_output  index of the largest logit (NUM_CLASSES = no result yet)
//   max_value      logit value at argmax_output
// The master modport is the logit producer; the slave modport is the argmax unit.
interface argmax_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     busy;
    logic                     done;
    logic [IDX_W-1:0]         argmax_output;
    logic signed [DATA_W-1:0] max_value;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, busy, done, argmax_output, max_value
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, busy, done, argmax_output, max_value
    );
endinterface

// File: rtl/argmax_unit.sv
// argmax_unit: final classification stage. Collects NUM_CLASSES signed logits
// from a valid/ready stream (beat k = class k), tracks the running maximum and
// commits the winning index and value once the last beat is accepted.
// The committed result is held until the next commit; before any commit the
// index reads NUM_CLASSES, which the display decoder renders as blank.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous, active-high reset
//   bus    argmax_if.slave: start/in_valid/in_data in; in_ready/busy/done/
//          argmax_output/max_value out
module argmax_unit #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4
) (
    input  logic     clk,
    input  logic     reset,
    argmax_if.slave  bus
);
    localparam int               CNT_W     = $clog2(NUM_CLASSES);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] NO_RESULT = IDX_W'(NUM_CLASSES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         count;
    logic signed [DATA_W-1:0] best_val;
    logic [IDX_W-1:0]         best_idx;
    logic                     in_ready_r;
    logic                     busy_r;
    logic                     done_r;
    logic [IDX_W-1:0]         argmax_r;
    logic signed [DATA_W-1:0] max_r;

    logic                     accept;
    logic                     take_beat;
    logic signed [DATA_W-1:0] next_val;
    logic [IDX_W-1:0]         next_idx;

    // in_ready_r is high exactly while collecting, so it doubles as the
    // "in COLLECT" qualifier for the handshake.
    assign accept    = in_ready_r && bus.in_valid;

    // The first beat of a frame always seeds the running best; later beats
    // replace it only when strictly larger, so ties keep the lower index.
    assign take_beat = (count == '0) || (bus.in_data > best_val);
    assign next_val  = take_beat ? bus.in_data : best_val;
    assign next_idx  = take_beat ? IDX_W'(count) : best_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            argmax_r   <= NO_RESULT;
            max_r      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_COLLECT;
                        count      <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (bus.start) begin
                        // Restart wins over a coincident beat; that beat is dropped.
                        count <= '0;
                    end else if (accept) begin
                        best_val <= next_val;
                        best_idx <= next_idx;
                        if (count == LAST_CNT) begin
                            // The final beat's compare feeds the outputs directly.
                            argmax_r   <= next_idx;
                            max_r      <= next_val;
                            state      <= S_DONE;
                            count      <= '0;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.argmax_output = argmax_r;
    assign bus.max_value     = max_r;

endmodule
